// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, MSB or LSB first.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             qout,
  output logic             qoutb,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_next;

  // Handshake: a word transfers on a rising edge where din_valid && din_ready.
  // din_ready is a pure decode of state, masked by rst so reset wins over accept.
  assign din_ready = (state == IDLE) && !rst;
  assign busy      = (state == SHIFT);

  // The register always holds the current bit at the output end, so the next
  // bit is the neighbour of that end.
  assign first_bit  = LSB_FIRST ? din[0]   : din[WIDTH-1];
  assign next_bit   = LSB_FIRST ? shreg[1] : shreg[WIDTH-2];
  assign shreg_next = LSB_FIRST ? (shreg >> 1) : (shreg << 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      qout  <= 1'b0;
      qoutb <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (din_valid) begin
            state <= SHIFT;
            shreg <= din;
            cnt   <= '0;
            qout  <= first_bit;
            qoutb <= ~first_bit;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            state <= IDLE;
            qout  <= 1'b0;
            qoutb <= 1'b1;
            done  <= 1'b1;
          end else begin
            cnt   <= cnt + 1'b1;
            shreg <= shreg_next;
            qout  <= next_bit;
            qoutb <= ~next_bit;
          end
        end
        default: begin
          state <= IDLE;
          qout  <= 1'b0;
          qoutb <= 1'b1;
        end
      endcase
    end
  end

endmodule
